// File: rtl/mac_sequencer.sv
// ---------------------------------------------------------------------------
// mac_sequencer
//
// Control sequencer for the MAC datapath. An accepted start latches a job
// length, spends one cycle clearing the accumulator, then enables
// accumulation for exactly that many qualified cycles (pausing while RUN_IN
// is low), and finally pulses DONE_OUT for one cycle.
//
// Parameters:
//   CNT_W      width of the length register and cycle counter
//              (maximum run length 2^CNT_W - 1)
//
// Ports:
//   CLK        clock, all state updates on the rising edge
//   RESET_IN   asynchronous active-low reset
//   START_IN   start request, only honoured in IDLE (and in DONE when
//              auto-restart is built in)
//   LEN_IN     number of accumulate cycles, latched on an accepted start
//   RUN_IN     run/pause qualifier while accumulating
//   ABORT_IN   synchronous abort back to IDLE without a DONE pulse
//   RUN_OUT    accumulate enable to the MAC
//   CLEAR_OUT  accumulator clear, one cycle per job
//   DONE_OUT   one-cycle job-complete pulse
//   BUSY_OUT   high while a job is in progress (CLEAR, ACCUM, DONE)
//   COUNT_OUT  accumulate cycles completed in the current job
//
// Build option:
//   MAC_SEQ_AUTO_RESTART_EN  when defined, a start request seen in DONE
//                            launches the next job directly into CLEAR.
// ---------------------------------------------------------------------------
module mac_sequencer #(
  parameter int CNT_W = 4
) (
  input  logic             CLK,
  input  logic             RESET_IN,
  input  logic             START_IN,
  input  logic [CNT_W-1:0] LEN_IN,
  input  logic             RUN_IN,
  input  logic             ABORT_IN,
  output logic             RUN_OUT,
  output logic             CLEAR_OUT,
  output logic             DONE_OUT,
  output logic             BUSY_OUT,
  output logic [CNT_W-1:0] COUNT_OUT
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    ACCUM = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] len_q, len_d;
  logic [CNT_W-1:0] count_q, count_d;

  // State, latched length and progress counter.
  always_ff @(posedge CLK or negedge RESET_IN) begin
    if (!RESET_IN) begin
      state_q <= IDLE;
      len_q   <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      count_q <= count_d;
    end
  end

  // Next-state and output decode. Abort is applied last so it overrides
  // whatever the state case decided, including the combinational enables.
  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    count_d   = count_q;
    RUN_OUT   = 1'b0;
    CLEAR_OUT = 1'b0;
    DONE_OUT  = 1'b0;
    BUSY_OUT  = 1'b0;

    case (state_q)
      IDLE: begin
        if (START_IN) begin
          len_d   = LEN_IN;
          count_d = '0;
          state_d = CLEAR;
        end
      end

      CLEAR: begin
        CLEAR_OUT = 1'b1;
        BUSY_OUT  = 1'b1;
        // A zero-length job skips accumulation entirely.
        state_d   = (len_q == '0) ? DONE : ACCUM;
      end

      ACCUM: begin
        BUSY_OUT = 1'b1;
        RUN_OUT  = RUN_IN;
        if (RUN_IN) begin
          count_d = count_q + CNT_W'(1);
          if (count_q == len_q - CNT_W'(1)) begin
            state_d = DONE;
          end
        end
      end

      DONE: begin
        DONE_OUT = 1'b1;
        BUSY_OUT = 1'b1;
        state_d  = IDLE;
`ifdef MAC_SEQ_AUTO_RESTART_EN
        // Back-to-back job: reload and go straight to the clear cycle.
        if (START_IN) begin
          len_d   = LEN_IN;
          count_d = '0;
          state_d = CLEAR;
        end
`endif
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    if (ABORT_IN) begin
      state_d   = IDLE;
      count_d   = '0;
      len_d     = len_q;
      RUN_OUT   = 1'b0;
      CLEAR_OUT = 1'b0;
    end
  end

  assign COUNT_OUT = count_q;

endmodule

// File: tb/tb_mac_sequencer.sv
// ---------------------------------------------------------------------------
// tb_mac_sequencer
//
// Self-checking bench for mac_sequencer. Jobs are described by their length,
// stall pattern and optional abort point; the expected per-cycle outputs are
// derived from how many qualified run cycles have elapsed in the job.
// ---------------------------------------------------------------------------
module tb_mac_sequencer;

  localparam int CNT_W = 4;

  logic             CLK;
  logic             RESET_IN;
  logic             START_IN;
  logic [CNT_W-1:0] LEN_IN;
  logic             RUN_IN;
  logic             ABORT_IN;
  logic             RUN_OUT;
  logic             CLEAR_OUT;
  logic             DONE_OUT;
  logic             BUSY_OUT;
  logic [CNT_W-1:0] COUNT_OUT;

  int checks = 0;
  int errors = 0;
  int modelCount = 0;

  mac_sequencer #(.CNT_W(CNT_W)) dut (
    .CLK       (CLK),
    .RESET_IN  (RESET_IN),
    .START_IN  (START_IN),
    .LEN_IN    (LEN_IN),
    .RUN_IN    (RUN_IN),
    .ABORT_IN  (ABORT_IN),
    .RUN_OUT   (RUN_OUT),
    .CLEAR_OUT (CLEAR_OUT),
    .DONE_OUT  (DONE_OUT),
    .BUSY_OUT  (BUSY_OUT),
    .COUNT_OUT (COUNT_OUT)
  );

  // 10-unit clock period.
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Let combinational outputs settle, then compare all outputs.
  task automatic checkOutput(input string tag, input bit expRun, input bit expClear,
                             input bit expDone, input bit expBusy, input int expCount);
    #1;
    chk({tag, ".run"},   32'(RUN_OUT),   32'(expRun));
    chk({tag, ".clear"}, 32'(CLEAR_OUT), 32'(expClear));
    chk({tag, ".done"},  32'(DONE_OUT),  32'(expDone));
    chk({tag, ".busy"},  32'(BUSY_OUT),  32'(expBusy));
    chk({tag, ".count"}, 32'(COUNT_OUT), 32'(expCount));
  endtask

  // Run one job from IDLE. stallAt inserts two stall cycles once that many
  // run cycles are done; abortAt aborts on that (1-based) run cycle; noisy
  // toggles START_IN/LEN_IN mid-job; chainLen requests another job in DONE.
  task automatic applyStimulus(input int len, input int stallAt, input int stallPct,
                               input int abortAt, input bit noisy, input int chainLen);
    int  curLen;
    int  nxt;
    int  done;
    int  iter;
    int  stalls;
    bit  ri;
    bit  ab;
    curLen = len;
    nxt    = chainLen;
    START_IN = 1'b1;
    LEN_IN   = CNT_W'(len);
    ABORT_IN = 1'b0;
    RUN_IN   = 1'($urandom_range(1));
    checkOutput("idle", 0, 0, 0, 0, modelCount);
    tick();
    while (1) begin
      START_IN = noisy ? 1'($urandom_range(1)) : 1'b0;
      LEN_IN   = CNT_W'($urandom);
      RUN_IN   = 1'($urandom_range(1));
      checkOutput("clear", 0, 1, 0, 1, 0);
      tick();
      done   = 0;
      iter   = 0;
      stalls = 0;
      while (done < curLen && iter < 1000) begin
        if (stallAt >= 0 && done == stallAt && stalls < 2) begin
          ri = 1'b0;
          stalls++;
        end else begin
          ri = ($urandom_range(99) >= stallPct);
        end
        ab = (abortAt > 0) && ri && (done == abortAt - 1);
        RUN_IN   = ri;
        ABORT_IN = ab;
        START_IN = noisy ? 1'($urandom_range(1)) : 1'b0;
        LEN_IN   = CNT_W'($urandom);
        checkOutput("accum", ri && !ab, 0, 0, 1, done);
        tick();
        if (ab) begin
          ABORT_IN   = 1'b0;
          START_IN   = 1'b0;
          modelCount = 0;
          checkOutput("after_abort", 0, 0, 0, 0, 0);
          return;
        end
        if (ri) done++;
        iter++;
      end
      if (iter >= 1000) chk("accum_budget", 32'(done), 32'(curLen));
      RUN_IN   = 1'b1;
      ABORT_IN = 1'b0;
      START_IN = (nxt >= 0);
      LEN_IN   = (nxt >= 0) ? CNT_W'(nxt) : CNT_W'($urandom);
      checkOutput("done", 0, 0, 1, 1, curLen);
      tick();
      modelCount = curLen;
`ifdef MAC_SEQ_AUTO_RESTART_EN
      if (nxt >= 0) begin
        curLen  = nxt;
        nxt     = -1;
        stallAt = -1;
        abortAt = 0;
        continue;
      end
`endif
      START_IN = 1'b0;
      checkOutput("idle_after", 0, 0, 0, 0, curLen);
      break;
    end
  endtask

  initial begin
    RESET_IN = 1'b0;
    START_IN = 1'b1;
    LEN_IN   = CNT_W'(5);
    RUN_IN   = 1'b1;
    ABORT_IN = 1'b0;

    // Reset held with a start request pending.
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("reset_held", 0, 0, 0, 0, 0);
    end
    START_IN = 1'b0;
    RESET_IN = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("post_reset", 0, 0, 0, 0, 0);
    end

    // Basic job, no stalls.
    applyStimulus(3, -1, 0, 0, 1'b0, -1);
    // Two stall cycles in the middle of a length-4 job.
    applyStimulus(4, 2, 0, 0, 1'b0, -1);
    // Zero-length job.
    applyStimulus(0, -1, 0, 0, 1'b0, -1);
    // Maximum length, abort on the 7th run cycle, noisy start/length inputs.
    applyStimulus(15, -1, 0, 7, 1'b1, -1);
    // Maximum length to completion.
    applyStimulus(15, -1, 0, 0, 1'b0, -1);
    // Start request in DONE: restarts or is ignored depending on the build.
    applyStimulus(2, -1, 0, 0, 1'b0, 1);

    // Abort together with start in IDLE drops the start.
    START_IN = 1'b1;
    ABORT_IN = 1'b1;
    LEN_IN   = CNT_W'(6);
    tick();
    START_IN   = 1'b0;
    ABORT_IN   = 1'b0;
    modelCount = 0;
    checkOutput("abort_start", 0, 0, 0, 0, 0);

    // Randomized jobs.
    for (int j = 0; j < 12; j++) begin
      int rl;
      int ra;
      rl = int'($urandom_range(15));
      ra = ($urandom_range(3) == 0 && rl > 0) ? int'($urandom_range(rl, 1)) : 0;
      applyStimulus(rl, -1, 30, ra, 1'($urandom_range(1)), -1);
      for (int k = 0; k < int'($urandom_range(2)); k++) begin
        tick();
        checkOutput("rand_idle", 0, 0, 0, 0, modelCount);
      end
    end

    // Asynchronous reset in the middle of a job.
    START_IN = 1'b1;
    LEN_IN   = CNT_W'(10);
    RUN_IN   = 1'b1;
    tick();
    START_IN = 1'b0;
    tick();
    tick();
    checkOutput("pre_reset_accum", 1, 0, 0, 1, 1);
    #1;
    RESET_IN = 1'b0;
    modelCount = 0;
    checkOutput("mid_reset", 0, 0, 0, 0, 0);
    tick();
    RESET_IN = 1'b1;
    tick();
    checkOutput("mid_reset_release", 0, 0, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
